// File: rtl/uart_wb_arb.sv
// uart_wb_arb: two-requester arbiter/sequencer in front of the UART wrapper's
// single wishbone master port. It runs one single-beat transaction at a time,
// returns a one-cycle response to the owner, and answers a hung bus with an
// error response after TIMEOUT_CYC strobe cycles.
// Optional build macro: UART_WB_ARB_IRQ_PRIO_EN gives requester 1 strict
// priority while irq is high. Without it, arbitration is pure round-robin.
module uart_wb_arb #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 32,
  parameter int SELECT_W    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                irq,
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [SELECT_W-1:0] req0_sel,
  output logic                req0_ready,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp0_err,
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [SELECT_W-1:0] req1_sel,
  output logic                req1_ready,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                rsp1_err,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_adr,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [SELECT_W-1:0] wb_sel,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack
);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t              state, state_nxt;
  logic                owner;     // 0 = requester 0, 1 = requester 1
  logic                rr_last;   // winner of the most recent grant
  logic [15:0]         cnt;       // strobe cycles spent in BUS
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                prio1;
  logic                pick1;
  logic                idle;
  logic                grant;
  logic                expire;

`ifdef UART_WB_ARB_IRQ_PRIO_EN
  assign prio1 = irq;
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign prio1      = 1'b0;
`endif

  // Grant is combinational in IDLE. It is held off while reset is asserted so
  // that every output stays low during reset.
  assign idle       = (state == IDLE) && rstn;
  assign pick1      = req1_valid && (!req0_valid || !rr_last || prio1);
  assign req1_ready = idle && pick1;
  assign req0_ready = idle && req0_valid && !pick1;
  assign grant      = req0_ready || req1_ready;

  // Expiry is flagged on the TIMEOUT_CYC-th strobe cycle. Counting starts at 0.
  assign expire = (cnt == 16'(TIMEOUT_CYC - 1));

  // The bus strobe is a decode of the state, so an asynchronous reset drops it at once.
  assign wb_cyc = (state == BUS);
  assign wb_stb = (state == BUS);

  // Responses are visible only during the single RSP cycle of their owner.
  assign rsp0_valid = (state == RSP) && !owner;
  assign rsp1_valid = (state == RSP) && owner;
  assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

  // Next-state decode for the IDLE -> BUS -> RSP -> IDLE sequence.
  always_comb begin
    // NOTE: assign a default first so every path writes state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = BUS;
      BUS:     if (wb_ack || expire) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so that all flops update together.
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch, round-robin pointer, timeout counter and response capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      cnt      <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_o <= '0;
      wb_sel   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            owner    <= pick1;
            rr_last  <= pick1;
            wb_we    <= pick1 ? req1_we    : req0_we;
            wb_adr   <= pick1 ? req1_addr  : req0_addr;
            wb_dat_o <= pick1 ? req1_wdata : req0_wdata;
            wb_sel   <= pick1 ? req1_sel   : req0_sel;
          end
        end
        BUS: begin
          cnt <= cnt + 16'd1;
          // An ack on the expiry cycle still counts as a good completion.
          if (wb_ack) begin
            rdata_q <= wb_we ? '0 : wb_dat_i;
            err_q   <= 1'b0;
          end else if (expire) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RSP:     cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_arb.sv
// Self-checking bench for uart_wb_arb (TIMEOUT_CYC = 8). Expected responses are
// pushed to a scoreboard when a grant is observed and popped when the DUT
// raises a response strobe.
module tb_uart_wb_arb;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              irq;
  logic              req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, rsp0_rdata;
  logic [SEL_W-1:0]  req0_sel;
  logic              req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, rsp1_rdata;
  logic [SEL_W-1:0]  req1_sel;
  logic              wb_cyc, wb_stb, wb_we, wb_ack;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat_o, wb_dat_i;
  logic [SEL_W-1:0]  wb_sel;

  // Bus slave model: either a zero-wait responder returning 0x100 + address,
  // or fully manual ack/data controlled by the directed steps.
  logic              ack_auto, ack_man;
  logic [DATA_W-1:0] dat_man;
  assign wb_ack   = ack_auto ? wb_stb : ack_man;
  assign wb_dat_i = ack_auto ? (32'h100 + 32'(wb_adr)) : dat_man;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_wb_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SELECT_W(SEL_W), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rstn(rstn), .irq(irq),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the response currently on the bus against the scoreboard head.
  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_owner"}, 32'({rsp1_valid, rsp0_valid}), e.owner ? 32'd2 : 32'd1);
      check({tag, "_rdata"}, e.owner ? rsp1_rdata : rsp0_rdata, e.rdata);
      check({tag, "_err"},   32'(e.owner ? rsp1_err : rsp0_err), 32'(e.err));
    end
  endtask

  // Run one transaction that was granted on the current cycle. ack_at is the
  // strobe cycle (1-based) on which ack is raised; 0 means never.
  task automatic run_txn(input string tag, input int ack_at, input logic [31:0] dat,
                         output int stb_cycles);
    bit got = 1'b0;
    stb_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      if (rsp0_valid || rsp1_valid) begin
        ack_man = 1'b0;
        check({tag, "_stb_low_in_rsp"}, 32'(wb_stb), 32'd0);
        check_rsp(tag);
        got = 1'b1;
        break;
      end
      if (wb_stb) begin
        stb_cycles++;
        ack_man = (stb_cycles == ack_at);
        dat_man = dat;
      end
    end
    ack_man = 1'b0;
    check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    @(negedge clk); #1;
    check({tag, "_rsp_one_cycle"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
  endtask

  // Both requesters held valid with a zero-wait slave. Called at a negedge that
  // begins an IDLE cycle; returns at the negedge that begins the next IDLE cycle.
  // owners bit g is the expected winner of the g-th grant.
  task automatic grant_loop(input string tag, input int n, input logic [3:0] owners);
    logic g, o;
    for (int c = 0; c < 3 * n; c++) begin
      #1;
      g = (c % 3 == 0);
      o = owners[c / 3];
      check({tag, "_ready"}, 32'({req1_ready, req0_ready}), g ? (o ? 32'd2 : 32'd1) : 32'd0);
      if (g) sb.push_back('{o, o ? 32'h100 + 32'(req1_addr) : 32'h100 + 32'(req0_addr), 1'b0});
      check({tag, "_rsp_slot"}, 32'(rsp0_valid || rsp1_valid), 32'(c % 3 == 2));
      if (rsp0_valid || rsp1_valid) check_rsp(tag);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0; irq = 1'b0;
    ack_auto = 1'b0; ack_man = 1'b0; dat_man = '0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; req1_sel = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_bus", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
    check("reset_adr_dat", 32'(wb_adr) | wb_dat_o | 32'(wb_sel), 32'd0);
    check("reset_rsp", 32'({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err}), 32'd0);
    // Requests seen during reset must not be accepted
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 3'd1; req1_addr = 3'd2;
    #1;
    check("reset_no_ready", 32'({req1_ready, req0_ready}), 32'd0);

    // T2: both valid from reset, zero-wait ack, alternate 0,1,0,1 every 3 cycles
    ack_auto = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    grant_loop("t2", 4, 4'b1010);
    req0_valid = 1'b0; req1_valid = 1'b0;
    ack_auto = 1'b0;
    @(negedge clk);

    // T1: req0 read addr 5, ack on 4th strobe cycle, data 0x60
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd5; req0_sel = 4'hf;
    #1;
    check("t1_ready", 32'({req1_ready, req0_ready}), 32'd1);
    sb.push_back('{1'b0, 32'h60, 1'b0});
    @(negedge clk); #1;
    check("t1_stb", 32'({wb_cyc, wb_stb, wb_we}), 32'b110);
    check("t1_adr", 32'(wb_adr), 32'd5);
    check("t1_no_ready_in_bus", 32'({req1_ready, req0_ready}), 32'd0);
    req0_valid = 1'b0;
    ack_man = 1'b0; dat_man = 32'h60;
    n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (wb_stb) n++;
      ack_man = (n == 4);
    end
    @(negedge clk); #1;
    ack_man = 1'b0;
    check("t1_stb_cycles", 32'(n), 32'd4);
    check("t1_rsp_after_ack", 32'(rsp0_valid), 32'd1);
    if (rsp0_valid || rsp1_valid) check_rsp("t1");
    @(negedge clk); #1;
    check("t1_rsp_one_cycle", 32'({rsp1_valid, rsp0_valid}), 32'd0);

    // T3: req1 write addr 0 data 0x41, never acked -> timeout after 8 strobes
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 3'd0; req1_wdata = 32'h41; req1_sel = 4'hf;
    #1;
    check("t3_ready", 32'({req1_ready, req0_ready}), 32'd2);
    sb.push_back('{1'b1, 32'h0, 1'b1});
    run_txn("t3", 0, 32'hdead_beef, n);
    check("t3_stb_cycles", 32'(n), 32'd8);

    // T4: ack on exactly the 8th strobe cycle -> good completion with data
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd3; req0_sel = 4'h3;
    #1;
    check("t4_ready", 32'({req1_ready, req0_ready}), 32'd1);
    sb.push_back('{1'b0, 32'hABCD, 1'b0});
    run_txn("t4", 8, 32'hABCD, n);
    check("t4_stb_cycles", 32'(n), 32'd8);

    // T5: reset during BUS drops the strobe at once, no response afterwards
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd4;
    #1;
    check("t5_ready", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk); #1;
    check("t5_stb_before_reset", 32'(wb_stb), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t5_bus_dropped", 32'({wb_cyc, wb_stb}), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("t5_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    end
    req0_valid = 1'b1; req0_addr = 3'd6; req0_we = 1'b0;
    req1_valid = 1'b1; req1_addr = 3'd7; req1_we = 1'b0;
    ack_auto = 1'b1;
    #1;
    check("t5_tie_after_reset", 32'({req1_ready, req0_ready}), 32'd1);
    sb.push_back('{1'b0, 32'h106, 1'b0});
    run_txn("t5", 0, 32'h0, n);
    check("t5_stb_cycles", 32'(n), 32'd1);

`ifdef UART_WB_ARB_IRQ_PRIO_EN
    // T6: rr_last is 0 here; irq forces requester 1 three times, then alternation
    @(negedge clk);
    irq = 1'b1;
    req0_valid = 1'b1; req0_addr = 3'd1;
    req1_valid = 1'b1; req1_addr = 3'd2;
    grant_loop("t6_irq", 3, 4'b0111);
    irq = 1'b0;
    grant_loop("t6_rr", 2, 4'b0010);
    req0_valid = 1'b0; req1_valid = 1'b0;
`endif

    ack_auto = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
